// File: rtl/decode_queue_if.sv
// Fetch-to-issue handshake bundle for the decode queue: fetch valid/ready on the
// in side, decoded head entry with valid/ready on the out side.
interface decode_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [5:0]  out_id;
    logic [7:0]  out_class;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_id, out_class, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_id, out_class, out_illegal
    );
endinterface

// File: rtl/decode_queue.sv
// MIPS decode stage: words are decoded as they enter a DEPTH-entry FIFO and the
// decoded head is presented to issue; flush empties the queue on redirect.
module decode_queue #(
    parameter int DEPTH      = 4,
    parameter bit ENABLE_CP0 = 1'b1,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    decode_queue_if.slave    bus,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [5:0]       id_q    [DEPTH];
    logic [7:0]       cls_q   [DEPTH];
    logic             push;
    logic             pop;
    logic [5:0]       dec_id;
    logic [7:0]       dec_cls;

    function automatic logic [5:0] decode_id(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [5:0] fn);
        logic [5:0] id;
        id = 6'd0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: id = 6'd1;
                    6'h21: id = 6'd2;
                    6'h22: id = 6'd3;
                    6'h23: id = 6'd4;
                    6'h00: id = 6'd5;
                    6'h02: id = 6'd6;
                    6'h03: id = 6'd7;
                    6'h04: id = 6'd8;
                    6'h06: id = 6'd9;
                    6'h07: id = 6'd10;
                    6'h24: id = 6'd11;
                    6'h25: id = 6'd12;
                    6'h26: id = 6'd13;
                    6'h27: id = 6'd14;
                    6'h2a: id = 6'd15;
                    6'h2b: id = 6'd16;
                    6'h08: id = 6'd41;
                    6'h09: id = 6'd42;
                    6'h18: id = 6'd43;
                    6'h19: id = 6'd44;
                    6'h1a: id = 6'd45;
                    6'h1b: id = 6'd46;
                    6'h11: id = 6'd47;
                    6'h13: id = 6'd48;
                    6'h10: id = 6'd49;
                    6'h12: id = 6'd50;
                    default: id = 6'd0;
                endcase
            end
            // regimm branches are selected by the rt field
            6'h01: begin
                if (rt == 5'd0)      id = 6'd29;
                else if (rt == 5'd1) id = 6'd30;
            end
            6'h08: id = 6'd17;
            6'h09: id = 6'd18;
            6'h0c: id = 6'd19;
            6'h0e: id = 6'd20;
            6'h0f: id = 6'd21;
            6'h0d: id = 6'd22;
            6'h0a: id = 6'd23;
            6'h0b: id = 6'd24;
            6'h04: id = 6'd25;
            6'h05: id = 6'd26;
            6'h06: id = 6'd27;
            6'h07: id = 6'd28;
            6'h2b: id = 6'd31;
            6'h29: id = 6'd32;
            6'h28: id = 6'd33;
            6'h20: id = 6'd34;
            6'h24: id = 6'd35;
            6'h21: id = 6'd36;
            6'h25: id = 6'd37;
            6'h23: id = 6'd38;
            6'h02: id = 6'd39;
            6'h03: id = 6'd40;
            6'h10: begin
                if (ENABLE_CP0) begin
                    if (rs == 5'h10)     id = 6'd51;
                    else if (rs == 5'd0) id = 6'd52;
                    else if (rs == 5'd4) id = 6'd53;
                end
            end
            default: id = 6'd0;
        endcase
        return id;
    endfunction

    // Class bits {mft,ltype,stype,jtype,mtype,btype,itype,rtype}; illegal (id 0) gives 0
    function automatic logic [7:0] class_of(input logic [5:0] id, input logic [5:0] op);
        logic [7:0] c;
        c    = 8'd0;
        c[0] = (op == 6'h00) && (id != 6'd0);
        c[1] = (id >= 6'd17) && (id <= 6'd24);
        c[2] = (id >= 6'd25) && (id <= 6'd30);
        c[3] = (id >= 6'd31) && (id <= 6'd38);
        c[4] = (id >= 6'd39) && (id <= 6'd42);
        c[5] = (id >= 6'd31) && (id <= 6'd33);
        c[6] = (id >= 6'd34) && (id <= 6'd38);
        c[7] = ((id >= 6'd43) && (id <= 6'd50)) || (id == 6'd52) || (id == 6'd53);
        return c;
    endfunction

    assign dec_id  = decode_id(bus.in_instr[31:26], bus.in_instr[25:21],
                               bus.in_instr[20:16], bus.in_instr[5:0]);
    assign dec_cls = class_of(dec_id, bus.in_instr[31:26]);

    assign bus.out_valid = (count != '0);
    assign bus.in_ready  = (count != CNT_W'(DEPTH));
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage holds data only; empty-queue outputs are forced to zero below
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            instr_q[wr_ptr] <= bus.in_instr;
            pc_q[wr_ptr]    <= bus.in_pc;
            id_q[wr_ptr]    <= dec_id;
            cls_q[wr_ptr]   <= dec_cls;
        end
    end

    assign bus.out_instr   = bus.out_valid ? instr_q[rd_ptr] : 32'd0;
    assign bus.out_pc      = bus.out_valid ? pc_q[rd_ptr]    : 32'd0;
    assign bus.out_id      = bus.out_valid ? id_q[rd_ptr]    : 6'd0;
    assign bus.out_class   = bus.out_valid ? cls_q[rd_ptr]   : 8'd0;
    assign bus.out_illegal = bus.out_valid && (id_q[rd_ptr] == 6'd0);
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: one instance with CP0 decode enabled and one
// without, driven through the handshake interface with hand-computed expectations.
module tb_decode_queue;
    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       flush1;
    logic [2:0] count;
    logic [2:0] count1;
    int         checks;
    int         errors;

    logic [31:0] w5  [5];
    logic [5:0]  id5 [5];
    logic [7:0]  cl5 [5];

    decode_queue_if bus ();
    decode_queue_if bus1 ();

    decode_queue #(.DEPTH(4), .ENABLE_CP0(1'b1), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave), .count(count)
    );

    decode_queue #(.DEPTH(4), .ENABLE_CP0(1'b0), .CNT_W(3)) dut_nocp0 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .bus(bus1.slave), .count(count1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_head(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                               input logic [5:0] id, input logic [7:0] cls, input logic ill);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_instr"}, bus.out_instr, instr);
        check({tag, "_pc"}, bus.out_pc, pc);
        check({tag, "_id"}, {26'd0, bus.out_id}, {26'd0, id});
        check({tag, "_class"}, {24'd0, bus.out_class}, {24'd0, cls});
        check({tag, "_illegal"}, {31'd0, bus.out_illegal}, {31'd0, ill});
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; flush = 1'b0; flush1 = 1'b0;
        checks = 0; errors = 0;
        bus.in_valid = 1'b0;  bus.in_instr = '0;  bus.in_pc = '0;  bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_instr = '0; bus1.in_pc = '0; bus1.out_ready = 1'b0;

        w5[0] = 32'h20010001; id5[0] = 6'd17; cl5[0] = 8'h02;
        w5[1] = 32'h3C011234; id5[1] = 6'd21; cl5[1] = 8'h02;
        w5[2] = 32'h10220003; id5[2] = 6'd25; cl5[2] = 8'h04;
        w5[3] = 32'h0C000010; id5[3] = 6'd40; cl5[3] = 8'h10;
        w5[4] = 32'h00430018; id5[4] = 6'd43; cl5[4] = 8'h81;

        repeat (2) @(negedge clk);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_id", {26'd0, bus.out_id}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while two entries are held
        bus.in_valid = 1'b1; bus.in_instr = 32'h00221821; bus.in_pc = 32'h100;
        step();
        bus.in_instr = 32'h00221822; bus.in_pc = 32'h104;
        step();
        bus.in_valid = 1'b0;
        check("t1_count_before", {29'd0, count}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_count", {29'd0, count}, 32'd0);
        check("t1_async_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t1_async_out_pc", bus.out_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // addu with out_ready held high: visible next cycle, then popped
        bus.in_valid = 1'b1; bus.in_instr = 32'h00221821; bus.in_pc = 32'h200; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("t2_count1", {29'd0, count}, 32'd1);
        expect_head("t2_addu", 32'h00221821, 32'h200, 6'd2, 8'h01, 1'b0);
        step();
        bus.out_ready = 1'b0;
        check("t2_count0", {29'd0, count}, 32'd0);
        check("t2_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // lw, jr, bltz, illegal regimm
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h8C220004; bus.in_pc = 32'h300; step();
        bus.in_instr = 32'h03E00008; bus.in_pc = 32'h304; step();
        bus.in_instr = 32'h04200002; bus.in_pc = 32'h308; step();
        bus.in_instr = 32'h04220002; bus.in_pc = 32'h30C; step();
        bus.in_valid = 1'b0;
        check("t3_count4", {29'd0, count}, 32'd4);
        expect_head("t3_lw", 32'h8C220004, 32'h300, 6'd38, 8'h48, 1'b0);
        pop_one();
        expect_head("t3_jr", 32'h03E00008, 32'h304, 6'd41, 8'h11, 1'b0);
        pop_one();
        expect_head("t3_bltz", 32'h04200002, 32'h308, 6'd29, 8'h04, 1'b0);
        pop_one();
        expect_head("t3_regimm_bad", 32'h04220002, 32'h30C, 6'd0, 8'h00, 1'b1);
        pop_one();
        check("t3_empty", {29'd0, count}, 32'd0);

        // mfc0 with and without CP0 decode
        bus.in_valid = 1'b1;  bus.in_instr = 32'h40086000;  bus.in_pc = 32'h400;
        bus1.in_valid = 1'b1; bus1.in_instr = 32'h40086000; bus1.in_pc = 32'h400;
        step();
        bus.in_valid = 1'b0; bus1.in_valid = 1'b0;
        expect_head("t4_mfc0", 32'h40086000, 32'h400, 6'd52, 8'h80, 1'b0);
        check("t4_nocp0_valid", {31'd0, bus1.out_valid}, 32'd1);
        check("t4_nocp0_id", {26'd0, bus1.out_id}, 32'd0);
        check("t4_nocp0_class", {24'd0, bus1.out_class}, 32'd0);
        check("t4_nocp0_illegal", {31'd0, bus1.out_illegal}, 32'd1);
        bus1.out_ready = 1'b1;
        pop_one();
        bus1.out_ready = 1'b0;
        check("t4_nocp0_count", {29'd0, count1}, 32'd0);

        // Fill to DEPTH, fifth word held, then drain across pointer wrap
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_instr = w5[i]; bus.in_pc = 32'h500 + 32'(4 * i);
            step();
        end
        check("t5_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("t5_full_count", {29'd0, count}, 32'd4);
        bus.in_instr = w5[4]; bus.in_pc = 32'h510;
        step();
        check("t5_held_count", {29'd0, count}, 32'd4);
        expect_head("t5_head0", w5[0], 32'h500, id5[0], cl5[0], 1'b0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("t5_pop_full_count", {29'd0, count}, 32'd3);
        check("t5_pop_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("t5_refill_count", {29'd0, count}, 32'd4);
        for (int i = 1; i < 5; i++) begin
            expect_head($sformatf("t5_head%0d", i), w5[i], 32'h500 + 32'(4 * i), id5[i], cl5[i], 1'b0);
            pop_one();
        end
        check("t5_empty", {29'd0, count}, 32'd0);

        // count=3, push+pop keeps count, then push+pop+flush clears everything
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hAC220004; bus.in_pc = 32'h600; step();
        bus.in_instr = 32'h00221822; bus.in_pc = 32'h604; step();
        bus.in_instr = 32'h00021883; bus.in_pc = 32'h608; step();
        check("t6_count3", {29'd0, count}, 32'd3);
        expect_head("t6_sw", 32'hAC220004, 32'h600, 6'd31, 8'h28, 1'b0);
        bus.in_instr = 32'h24010005; bus.in_pc = 32'h60C; bus.out_ready = 1'b1;
        step();
        check("t6_pushpop_count", {29'd0, count}, 32'd3);
        expect_head("t6_sub", 32'h00221822, 32'h604, 6'd3, 8'h01, 1'b0);
        bus.in_instr = 32'h34010006; bus.in_pc = 32'h610; flush = 1'b1;
        step();
        flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check("t6_flush_count", {29'd0, count}, 32'd0);
        check("t6_flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("t6_after_count", {29'd0, count}, 32'd0);
        check("t6_after_out_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.in_valid = 1'b1; bus.in_instr = 32'h00000000; bus.in_pc = 32'h700;
        step();
        bus.in_valid = 1'b0;
        check("t6_next_count", {29'd0, count}, 32'd1);
        expect_head("t6_nop_sll", 32'h00000000, 32'h700, 6'd5, 8'h01, 1'b0);
        pop_one();
        check("t6_final_count", {29'd0, count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
